// File: rtl/dcache_line_seq_pkg.sv
// Shared constants, state encoding and helpers for the data-cache line sequencer.
// Default geometry: 512 words of 32 bits, 8-word lines.
package dcache_line_seq_pkg;

    localparam int ADDR_WIDTH_DEF = 9;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int BE_WIDTH_DEF   = DATA_WIDTH_DEF / 8;
    localparam int LINE_WORDS_DEF = 8;

    function automatic int beat_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_width(input int addr_width, input int line_words);
        return addr_width - $clog2(line_words);
    endfunction

    localparam int BEAT_W_DEF = beat_width(LINE_WORDS_DEF);
    localparam int IDX_W_DEF  = idx_width(ADDR_WIDTH_DEF, LINE_WORDS_DEF);

    // Sequencer states; IDLE is the only state that accepts CPU or line requests.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REFILL = 2'd1;
    localparam state_t ST_WB     = 2'd2;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_line_seq_if.sv
// Bundle of CPU, line-request, fill, writeback and SRAM signals around the sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface dcache_line_seq_if #(
    parameter int ADDR_WIDTH = dcache_line_seq_pkg::ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = dcache_line_seq_pkg::DATA_WIDTH_DEF,
    parameter int BE_WIDTH   = dcache_line_seq_pkg::BE_WIDTH_DEF,
    parameter int LINE_WORDS = dcache_line_seq_pkg::LINE_WORDS_DEF
);
    import dcache_line_seq_pkg::*;

    localparam int IDX_W = idx_width(ADDR_WIDTH, LINE_WORDS);

    logic                  cpu_wr_en;
    logic [ADDR_WIDTH-1:0] cpu_wr_addr;
    logic [DATA_WIDTH-1:0] cpu_wr_data;
    logic [BE_WIDTH-1:0]   cpu_wr_byte_en;
    logic                  cpu_wr_ready;
    logic                  cpu_rd_en;
    logic [ADDR_WIDTH-1:0] cpu_rd_addr;
    logic                  cpu_rd_ready;
    logic [DATA_WIDTH-1:0] cpu_rd_data;
    logic                  cpu_rd_valid;

    logic                  refill_req;
    logic [IDX_W-1:0]      refill_index;
    logic                  refill_ack;
    logic                  refill_done;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  fill_valid;
    logic                  fill_ready;

    logic                  wb_req;
    logic [IDX_W-1:0]      wb_index;
    logic                  wb_ack;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_valid;
    logic                  wb_last;
    logic                  wb_ready;

    logic                  sram_wr_en;
    logic [ADDR_WIDTH-1:0] sram_wr_addr;
    logic [DATA_WIDTH-1:0] sram_wr_data;
    logic [BE_WIDTH-1:0]   sram_wr_byte_en;
    logic [ADDR_WIDTH-1:0] sram_rd_addr;
    logic [DATA_WIDTH-1:0] sram_rd_data;

    logic [31:0]           stall_cnt;

    modport slave (
        input  cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_wr_byte_en,
        output cpu_wr_ready,
        input  cpu_rd_en, cpu_rd_addr,
        output cpu_rd_ready, cpu_rd_data, cpu_rd_valid,
        input  refill_req, refill_index,
        output refill_ack, refill_done,
        input  fill_data, fill_valid,
        output fill_ready,
        input  wb_req, wb_index,
        output wb_ack, wb_data, wb_valid, wb_last,
        input  wb_ready,
        output sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en, sram_rd_addr,
        input  sram_rd_data,
        output stall_cnt
    );

    modport master (
        output cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_wr_byte_en,
        input  cpu_wr_ready,
        output cpu_rd_en, cpu_rd_addr,
        input  cpu_rd_ready, cpu_rd_data, cpu_rd_valid,
        output refill_req, refill_index,
        input  refill_ack, refill_done,
        output fill_data, fill_valid,
        input  fill_ready,
        output wb_req, wb_index,
        input  wb_ack, wb_data, wb_valid, wb_last,
        output wb_ready,
        input  sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en, sram_rd_addr,
        output sram_rd_data,
        input  stall_cnt
    );

endinterface

// File: rtl/dcache_wb_skid.sv
// Two-entry valid/ready skid buffer holding SRAM read data for the writeback stream.
// Head entry drives out_data directly so it stays stable while out_ready is low.
module dcache_wb_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = entry0_q;
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    entry0_d = in_data;
                end else begin
                    entry1_d = in_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop: the new word becomes head only if the buffer held one.
                entry0_d = (count_q == 2'd1) ? in_data : entry1_q;
                entry1_d = in_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dcache_line_seq.sv
// Data-cache line sequencer: arbitrates CPU access, line refill and line writeback on one SRAM.
// Optional CPU stall counter enabled by defining DCACHE_LINE_SEQ_STALL_CNT_EN.
module dcache_line_seq
    import dcache_line_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BE_WIDTH   = BE_WIDTH_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input logic              clk,
    input logic              rst,
    dcache_line_seq_if.slave bus
);

    localparam int BEAT_W = beat_width(LINE_WORDS);
    localparam int IDX_W  = idx_width(ADDR_WIDTH, LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  line_idx_q, line_idx_d;
    logic [BEAT_W-1:0] fill_beat_q, fill_beat_d;
    logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
    logic [BEAT_W-1:0] sent_beat_q, sent_beat_d;
    logic              rd_all_q, rd_all_d;
    logic              rd_pend_q, rd_pend_d;
    logic              cpu_rd_valid_q, cpu_rd_valid_d;

    logic              in_idle, in_refill, in_wb;
    logic              grant_wb, grant_refill;
    logic              fill_fire, rd_issue, wb_fire, wb_valid_int;
    logic              skid_in_ready, skid_out_valid;
    logic [DATA_WIDTH-1:0] skid_out_data;
    logic [1:0]        skid_count;

    // Every request and handshake is qualified by !rst so a reset cycle is fully quiet.
    assign in_idle      = !rst && (state_q == ST_IDLE);
    assign in_refill    = !rst && (state_q == ST_REFILL);
    assign in_wb        = !rst && (state_q == ST_WB);
    assign grant_wb     = in_idle && bus.wb_req;
    assign grant_refill = in_idle && bus.refill_req && !bus.wb_req;
    assign fill_fire    = in_refill && bus.fill_valid;
    assign rd_issue     = in_wb && !rd_all_q && (({1'b0, rd_pend_q} + skid_count) < 2'd2);
    assign wb_valid_int = in_wb && skid_out_valid;
    assign wb_fire      = wb_valid_int && bus.wb_ready;

    assign bus.cpu_wr_ready = in_idle;
    assign bus.cpu_rd_ready = in_idle;
    assign bus.cpu_rd_valid = !rst && cpu_rd_valid_q;
    assign bus.cpu_rd_data  = (!rst && cpu_rd_valid_q) ? bus.sram_rd_data : '0;
    assign bus.refill_ack   = grant_refill;
    assign bus.refill_done  = fill_fire && (fill_beat_q == LAST_BEAT);
    assign bus.fill_ready   = in_refill;
    assign bus.wb_ack       = grant_wb;
    assign bus.wb_valid     = wb_valid_int;
    assign bus.wb_data      = wb_valid_int ? skid_out_data : '0;
    assign bus.wb_last      = wb_valid_int && (sent_beat_q == LAST_BEAT);

    // SRAM ports: CPU owns them in IDLE, the line engines own them otherwise.
    always_comb begin
        bus.sram_wr_en      = 1'b0;
        bus.sram_wr_addr    = '0;
        bus.sram_wr_data    = '0;
        bus.sram_wr_byte_en = '0;
        bus.sram_rd_addr    = '0;
        if (in_idle && bus.cpu_wr_en) begin
            bus.sram_wr_en      = 1'b1;
            bus.sram_wr_addr    = bus.cpu_wr_addr;
            bus.sram_wr_data    = bus.cpu_wr_data;
            bus.sram_wr_byte_en = bus.cpu_wr_byte_en;
        end else if (fill_fire) begin
            bus.sram_wr_en      = 1'b1;
            bus.sram_wr_addr    = {line_idx_q, fill_beat_q};
            bus.sram_wr_data    = bus.fill_data;
            bus.sram_wr_byte_en = '1;
        end
        if (in_idle && bus.cpu_rd_en) begin
            bus.sram_rd_addr = bus.cpu_rd_addr;
        end else if (rd_issue) begin
            bus.sram_rd_addr = {line_idx_q, rd_beat_q};
        end
    end

    dcache_wb_skid #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_wb && rd_pend_q && skid_in_ready),
        .in_data   (bus.sram_rd_data),
        .in_ready  (skid_in_ready),
        .out_valid (skid_out_valid),
        .out_data  (skid_out_data),
        .out_ready (in_wb && bus.wb_ready),
        .count     (skid_count)
    );

    always_comb begin
        state_d        = state_q;
        line_idx_d     = line_idx_q;
        fill_beat_d    = fill_beat_q;
        rd_beat_d      = rd_beat_q;
        sent_beat_d    = sent_beat_q;
        rd_all_d       = rd_all_q;
        rd_pend_d      = 1'b0;
        cpu_rd_valid_d = in_idle && bus.cpu_rd_en;
        case (state_q)
            ST_IDLE: begin
                fill_beat_d = '0;
                rd_beat_d   = '0;
                sent_beat_d = '0;
                rd_all_d    = 1'b0;
                if (grant_wb) begin
                    state_d    = ST_WB;
                    line_idx_d = bus.wb_index;
                end else if (grant_refill) begin
                    state_d    = ST_REFILL;
                    line_idx_d = bus.refill_index;
                end
            end
            ST_REFILL: begin
                if (fill_fire) begin
                    fill_beat_d = fill_beat_q + BEAT_ONE;
                    if (fill_beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WB: begin
                // rd_pend marks a read whose data lands in the skid buffer next cycle.
                rd_pend_d = rd_issue;
                if (rd_issue) begin
                    rd_beat_d = rd_beat_q + BEAT_ONE;
                    if (rd_beat_q == LAST_BEAT) begin
                        rd_all_d = 1'b1;
                    end
                end
                if (wb_fire) begin
                    sent_beat_d = sent_beat_q + BEAT_ONE;
                    if (sent_beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            line_idx_q     <= '0;
            fill_beat_q    <= '0;
            rd_beat_q      <= '0;
            sent_beat_q    <= '0;
            rd_all_q       <= 1'b0;
            rd_pend_q      <= 1'b0;
            cpu_rd_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_idx_q     <= line_idx_d;
            fill_beat_q    <= fill_beat_d;
            rd_beat_q      <= rd_beat_d;
            sent_beat_q    <= sent_beat_d;
            rd_all_q       <= rd_all_d;
            rd_pend_q      <= rd_pend_d;
            cpu_rd_valid_q <= cpu_rd_valid_d;
        end
    end

`ifdef DCACHE_LINE_SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    // A stall is any cycle where the CPU presents a request the sequencer cannot take.
    always_comb begin
        stall       = (bus.cpu_wr_en && !in_idle) || (bus.cpu_rd_en && !in_idle);
        stall_cnt_d = stall ? sat_inc32(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_line_seq.sv
// Directed testbench for dcache_line_seq: CPU access table plus refill, writeback,
// arbitration and reset-abort sequences against a behavioural one-cycle-latency SRAM.
module tb_dcache_line_seq;
    import dcache_line_seq_pkg::*;

    localparam int AW = ADDR_WIDTH_DEF;
    localparam int DW = DATA_WIDTH_DEF;
    localparam int BW = BE_WIDTH_DEF;
    localparam int LW = LINE_WORDS_DEF;
    localparam int IW = IDX_W_DEF;
    localparam int BEAT_W = BEAT_W_DEF;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dcache_line_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .LINE_WORDS(LW)) bus ();

    dcache_line_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .LINE_WORDS(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.sram_wr_en) begin
            for (int b = 0; b < BW; b++) begin
                if (bus.sram_wr_byte_en[b]) begin
                    mem[bus.sram_wr_addr][8*b +: 8] <= bus.sram_wr_data[8*b +: 8];
                end
            end
        end
        bus.sram_rd_data <= mem[bus.sram_rd_addr];
    end

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic [BW-1:0] wr_be;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic          exp_rd_valid;
        logic [DW-1:0] exp_rd_data;
    } vec_t;

    vec_t vecs [8];
    int   check_count = 0;
    int   fail_count  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.cpu_wr_en      = v.wr_en;
        bus.cpu_wr_addr    = v.wr_addr;
        bus.cpu_wr_data    = v.wr_data;
        bus.cpu_wr_byte_en = v.wr_be;
        bus.cpu_rd_en      = v.rd_en;
        bus.cpu_rd_addr    = v.rd_addr;
    endtask

    task automatic idleInputs();
        bus.cpu_wr_en = 1'b0; bus.cpu_wr_addr = '0; bus.cpu_wr_data = '0; bus.cpu_wr_byte_en = '0;
        bus.cpu_rd_en = 1'b0; bus.cpu_rd_addr = '0;
        bus.refill_req = 1'b0; bus.refill_index = '0; bus.fill_data = '0; bus.fill_valid = 1'b0;
        bus.wb_req = 1'b0; bus.wb_index = '0; bus.wb_ready = 1'b0;
    endtask

    // Presents LW back-to-back beats of base+i and checks each SRAM write and the done pulse.
    task automatic fillLine(input string tag, input logic [IW-1:0] idx, input logic [DW-1:0] base);
        int dones = 0;
        for (int i = 0; i < LW; i++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = base + DW'(i);
            #1;
            checkOutput({tag, "_wr_en"}, bus.sram_wr_en, 1'b1);
            checkOutput({tag, "_wr_addr"}, bus.sram_wr_addr, {idx, BEAT_W'(i)});
            checkOutput({tag, "_wr_data"}, bus.sram_wr_data, base + DW'(i));
            dones += int'(bus.refill_done);
            @(negedge clk);
        end
        bus.fill_valid = 1'b0;
        checkOutput({tag, "_done_count"}, dones, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int beats;
        int cyc;
        int gaps;
        int dones;
        int stalls;
        logic          prev_stall;
        logic [DW-1:0] held_data;

        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        bus.sram_rd_data = '0;

        vecs[0] = '{1'b1, 9'h012, 32'hA5A5A5A5, 4'b0011, 1'b0, 9'h000, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 9'h000, 32'h0,        4'b0000, 1'b1, 9'h012, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 9'h000, 32'h0,        4'b0000, 1'b0, 9'h000, 1'b1, 32'h0000A5A5};
        vecs[3] = '{1'b1, 9'h013, 32'h12345678, 4'b1111, 1'b1, 9'h012, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 9'h000, 32'h0,        4'b0000, 1'b1, 9'h013, 1'b1, 32'h0000A5A5};
        vecs[5] = '{1'b1, 9'h012, 32'hFFFFFFFF, 4'b1000, 1'b0, 9'h000, 1'b1, 32'h12345678};
        vecs[6] = '{1'b0, 9'h000, 32'h0,        4'b0000, 1'b1, 9'h012, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 9'h000, 32'h0,        4'b0000, 1'b0, 9'h000, 1'b1, 32'hFF00A5A5};

        // Reset, with a writeback request raised during reset that must wait for release.
        idleInputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus.wb_req = 1'b1; bus.wb_index = 6'd3;
        #1;
        checkOutput("rst_wr_ready", bus.cpu_wr_ready, 1'b0);
        checkOutput("rst_wb_ack", bus.wb_ack, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rearb_wb_ack", bus.wb_ack, 1'b1);
        @(negedge clk);
        bus.wb_req = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("abort_wb_valid", bus.wb_valid, 1'b0);
        checkOutput("abort_wb_last", bus.wb_last, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_wr_ready", bus.cpu_wr_ready, 1'b1);
        checkOutput("reset_rd_ready", bus.cpu_rd_ready, 1'b1);
        checkOutput("reset_rd_valid", bus.cpu_rd_valid, 1'b0);
        checkOutput("reset_fill_ready", bus.fill_ready, 1'b0);
        checkOutput("reset_wb_valid", bus.wb_valid, 1'b0);
        checkOutput("reset_sram_wr_en", bus.sram_wr_en, 1'b0);
        checkOutput("reset_stall_cnt", bus.stall_cnt, 32'd0);

        // CPU store/load table in IDLE.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_sram_wr_en", i), bus.sram_wr_en, vecs[i].wr_en);
            if (vecs[i].wr_en) begin
                checkOutput($sformatf("vec%0d_sram_wr_addr", i), bus.sram_wr_addr, vecs[i].wr_addr);
                checkOutput($sformatf("vec%0d_sram_wr_data", i), bus.sram_wr_data, vecs[i].wr_data);
                checkOutput($sformatf("vec%0d_sram_wr_be", i), bus.sram_wr_byte_en, vecs[i].wr_be);
            end
            if (vecs[i].rd_en) begin
                checkOutput($sformatf("vec%0d_sram_rd_addr", i), bus.sram_rd_addr, vecs[i].rd_addr);
            end
            checkOutput($sformatf("vec%0d_rd_valid", i), bus.cpu_rd_valid, vecs[i].exp_rd_valid);
            if (vecs[i].exp_rd_valid) begin
                checkOutput($sformatf("vec%0d_rd_data", i), bus.cpu_rd_data, vecs[i].exp_rd_data);
            end
        end
        @(negedge clk);
        idleInputs();

        // Refill line 3 with random gaps between beats.
        bus.refill_req = 1'b1; bus.refill_index = 6'd3;
        #1;
        checkOutput("refill_ack", bus.refill_ack, 1'b1);
        @(negedge clk);
        bus.refill_req = 1'b0;
        #1;
        checkOutput("refill_cpu_blocked", bus.cpu_wr_ready, 1'b0);
        checkOutput("refill_fill_ready", bus.fill_ready, 1'b1);
        dones = 0;
        for (int i = 0; i < LW; i++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                bus.fill_valid = 1'b0;
                #1;
                checkOutput("refill_gap_wr_en", bus.sram_wr_en, 1'b0);
                dones += int'(bus.refill_done);
                @(negedge clk);
            end
            bus.fill_valid = 1'b1;
            bus.fill_data  = 32'h100 + DW'(i);
            #1;
            checkOutput("refill_wr_addr", bus.sram_wr_addr, 9'h018 + AW'(i));
            checkOutput("refill_wr_be", bus.sram_wr_byte_en, 4'hF);
            checkOutput("refill_wr_en", bus.sram_wr_en, 1'b1);
            dones += int'(bus.refill_done);
            @(negedge clk);
        end
        bus.fill_valid = 1'b0;
        #1;
        checkOutput("refill_done_count", dones, 1);
        checkOutput("refill_back_idle", bus.cpu_wr_ready, 1'b1);

        // Writeback line 3 with wb_ready toggling 1,0,1,0...
        @(negedge clk);
        bus.wb_req = 1'b1; bus.wb_index = 6'd3;
        #1;
        checkOutput("wb_ack", bus.wb_ack, 1'b1);
        @(negedge clk);
        bus.wb_req = 1'b0;
        beats = 0; cyc = 0; prev_stall = 1'b0; held_data = '0;
        while (beats < LW && cyc < 200) begin
            bus.wb_ready = (cyc % 2 == 0);
            #1;
            if (prev_stall) begin
                checkOutput("wb_hold_valid", bus.wb_valid, 1'b1);
                checkOutput("wb_hold_data", bus.wb_data, held_data);
            end
            if (bus.wb_valid) begin
                checkOutput("wb_last", bus.wb_last, beats == LW - 1);
            end
            if (bus.wb_valid && bus.wb_ready) begin
                checkOutput("wb_data", bus.wb_data, 32'h100 + DW'(beats));
                beats++;
            end
            prev_stall = bus.wb_valid && !bus.wb_ready;
            held_data  = bus.wb_data;
            cyc++;
            @(negedge clk);
        end
        bus.wb_ready = 1'b0;
        #1;
        checkOutput("wb_beats", beats, LW);
        checkOutput("wb_back_idle", bus.cpu_wr_ready, 1'b1);
        checkOutput("wb_idle_valid", bus.wb_valid, 1'b0);

        // Reset while presenting refill beat 4; the line is then refilled cleanly.
        @(negedge clk);
        bus.refill_req = 1'b1; bus.refill_index = 6'd2;
        #1;
        checkOutput("abort_refill_ack", bus.refill_ack, 1'b1);
        @(negedge clk);
        bus.refill_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = 32'h200 + DW'(i);
            #1;
            checkOutput("abort_pre_wr_en", bus.sram_wr_en, 1'b1);
            @(negedge clk);
        end
        rst = 1'b1;
        bus.fill_data = 32'h204;
        #1;
        checkOutput("abort_rst_wr_en", bus.sram_wr_en, 1'b0);
        checkOutput("abort_rst_done", bus.refill_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.fill_valid = 1'b0;
        #1;
        checkOutput("abort_idle", bus.cpu_wr_ready, 1'b1);
        checkOutput("abort_done_after", bus.refill_done, 1'b0);
        checkOutput("abort_fill_ready", bus.fill_ready, 1'b0);
        @(negedge clk);
        bus.refill_req = 1'b1; bus.refill_index = 6'd2;
        #1;
        checkOutput("redo_refill_ack", bus.refill_ack, 1'b1);
        @(negedge clk);
        bus.refill_req = 1'b0;
        fillLine("redo", 6'd2, 32'h300);
        #1;
        checkOutput("redo_back_idle", bus.cpu_wr_ready, 1'b1);

        // Simultaneous writeback and refill requests with a CPU store held throughout.
        @(negedge clk);
        bus.wb_req = 1'b1; bus.wb_index = 6'd3;
        bus.refill_req = 1'b1; bus.refill_index = 6'd5;
        bus.cpu_wr_en = 1'b1; bus.cpu_wr_addr = 9'h040; bus.cpu_wr_data = 32'hDEADBEEF; bus.cpu_wr_byte_en = 4'hF;
        #1;
        checkOutput("arb_wb_ack", bus.wb_ack, 1'b1);
        checkOutput("arb_refill_ack_first", bus.refill_ack, 1'b0);
        @(negedge clk);
        bus.wb_req = 1'b0;
        bus.wb_ready = 1'b1;
        beats = 0; cyc = 0; stalls = 0;
        while (beats < LW && cyc < 100) begin
            #1;
            if (bus.cpu_wr_en && !bus.cpu_wr_ready) stalls++;
            checkOutput("arb_refill_ack_wait", bus.refill_ack, 1'b0);
            if (bus.wb_valid && bus.wb_ready) begin
                checkOutput("arb_wb_data", bus.wb_data, 32'h100 + DW'(beats));
                beats++;
            end
            cyc++;
            @(negedge clk);
        end
        #1;
        checkOutput("arb_wb_beats", beats, LW);
        checkOutput("arb_refill_ack", bus.refill_ack, 1'b1);
        checkOutput("arb_store_accepted", bus.cpu_wr_ready, 1'b1);
        @(negedge clk);
        bus.refill_req = 1'b0;
        bus.cpu_wr_en  = 1'b0;
        bus.wb_ready   = 1'b0;
        fillLine("arb_fill", 6'd5, 32'h400);
        #1;
        checkOutput("arb_back_idle", bus.cpu_wr_ready, 1'b1);
`ifdef DCACHE_LINE_SEQ_STALL_CNT_EN
        checkOutput("stall_cnt", bus.stall_cnt, stalls);
`else
        checkOutput("stall_cnt", bus.stall_cnt, 32'd0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/dcache_line_seq.md
DCACHE_LINE_SEQ -- requirements
Module: dcache_line_seq

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ADDR_WIDTH, 9, SRAM word address width
- DATA_WIDTH, 32, SRAM word width
- BE_WIDTH, 4, byte enables, DATA_WIDTH/8
- LINE_WORDS, 8, words per cache line (power of two); IDX_W = ADDR_WIDTH-log2(LINE_WORDS)

REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports (name, direction, width, meaning):
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- cpu_wr_en / cpu_wr_addr / cpu_wr_data / cpu_wr_byte_en  in  1/ADDR_WIDTH/DATA_WIDTH/BE_WIDTH  CPU store
- cpu_wr_ready  out  1  store accepted this cycle
- cpu_rd_en / cpu_rd_addr  in  1/ADDR_WIDTH  CPU load
- cpu_rd_ready  out  1  load accepted this cycle
- cpu_rd_data / cpu_rd_valid  out  DATA_WIDTH/1  load result
- refill_req / refill_index  in  1/IDX_W  line refill request, held until ack
- refill_ack / refill_done  out  1/1  one-cycle pulses
- fill_data / fill_valid  in  DATA_WIDTH/1  refill beats from memory
- fill_ready  out  1  beat accepted
- wb_req / wb_index  in  1/IDX_W  line writeback request, held until ack
- wb_ack  out  1  one-cycle pulse
- wb_data / wb_valid / wb_last  out  DATA_WIDTH/1/1  writeback stream
- wb_ready  in  1  downstream accepts beat
- sram_wr_en / sram_wr_addr / sram_wr_data / sram_wr_byte_en  out  SRAM write port
- sram_rd_addr  out  ADDR_WIDTH; sram_rd_data  in  DATA_WIDTH (one-cycle read latency)
- stall_cnt  out  32  CPU stall counter (REQ-014)

Function
REQ-003 SHALL implement FSM states IDLE, REFILL, WB; idle is the only state accepting requests.
REQ-004 In IDLE SHALL grant wb_req before refill_req when both are high; ack pulses the cycle of acceptance, and the FSM enters WB/REFILL next cycle with beat counters at 0.
REQ-005 In IDLE cpu_wr_ready=cpu_rd_ready=1; stores drive the SRAM write port combinationally the same cycle; loads drive sram_rd_addr and assert cpu_rd_valid with sram_rd_data exactly one cycle later.
REQ-006 Outside IDLE cpu_wr_ready=cpu_rd_ready=0; an acked request leaves no CPU access accepted in the ack cycle's following state.
REQ-007 REFILL: fill_ready=1; each fill_valid beat writes {refill_index, beat} with all byte enables set; beat wraps LINE_WORDS-1 -> done; refill_done pulses on the cycle of the last write; FSM returns to IDLE next cycle.
REQ-008 WB: SRAM reads issued for {wb_index, 0..LINE_WORDS-1} in order, only while in-flight plus buffered words < 2; data enters a 2-entry skid buffer; wb_valid=buffer non-empty.
REQ-009 wb_last SHALL be 1 exactly on beat LINE_WORDS-1; handshake (wb_valid&&wb_ready) of that beat returns FSM to IDLE next cycle; wb_ready low holds wb_data/wb_valid/wb_last stable, no beat lost or duplicated.
REQ-010 Beat counters SHALL be log2(LINE_WORDS) bits, unsigned, wrapping.

Reset
REQ-011 Reset SHALL force IDLE, clear counters and skid buffer; all outputs 0 except cpu_wr_ready=cpu_rd_ready=1 while reset low in IDLE.
REQ-012 Reset mid-REFILL/WB SHALL abort without refill_done, wb_last or further SRAM writes; partial line content is undefined.
REQ-013 Held requests at reset release SHALL be re-arbitrated from IDLE.

Configuration
REQ-014 Macro DCACHE_LINE_SEQ_STALL_CNT_EN: defined -> stall_cnt increments (saturating at 2^32-1) each cycle (cpu_wr_en&&!cpu_wr_ready)||(cpu_rd_en&&!cpu_rd_ready), cleared by rst; undefined -> stall_cnt tied to 0, no counter logic.

Structure
REQ-015 Package dcache_line_seq_pkg SHALL hold the state enum, LINE_WORDS default and derived width constants.
REQ-016 Skid buffer SHALL be sub-module dcache_wb_skid (2-entry, valid/ready, synchronous reset).

Verification
REQ-017 IDLE store addr 0x012, data 0xA5A5A5A5, be 4'b0011 then load 0x012 -> sram write same cycle, cpu_rd_valid next cycle after load with SRAM-returned data.
REQ-018 refill_req index 3, 8 fill beats 0x100..0x107 with random fill_valid gaps -> writes addr 0x018..0x01F, refill_done once, IDLE after.
REQ-019 wb_req index 3 with wb_ready toggling 1010... -> wb_data 0x100..0x107 in order, wb_last on 8th beat only, no duplicates.
REQ-020 wb_req and refill_req raised same cycle -> wb_ack first, refill_ack only after writeback completes; CPU stores stall throughout, stall_cnt (macro defined) equals stalled cycles.
REQ-021 rst asserted at refill beat 4 -> no refill_done, IDLE next cycle, subsequent refill completes normally.
